dispatch_buffer: RTL

//  2-wide in-order FIFO between decode_stage and rename/dispatch.
//  - Absorbs dispatch back-pressure so decode keeps running.
//  - Turns per-lane consumer takes into a single stall toward fetch/decode.
//  - Cleared by the pipeline-wide flush.

---
 rtl/core_pkg.sv | 12 +
 rtl/ring_ram_2w2r.sv | 29 ++
 rtl/dispatch_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core types: issue width, packed decoded-uop type and pointer-width helper.
package core_pkg;
  localparam int ISSUE_W = 2;
  localparam int UOP_W   = 64;

  typedef logic [UOP_W-1:0] decoded_uop_t;

  // Ring pointer width: index bits plus one wrap bit.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/ring_ram_2w2r.sv
// Storage array for the dispatch ring: two write ports, two async read ports.
// Write latency 1 cycle; reads are combinational; no backpressure (caller owns pointers).
// If both write ports hit one address, port 1 wins; the caller never does this.
module ring_ram_2w2r #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     i_we0,
  input  logic [$clog2(DEPTH)-1:0] i_waddr0,
  input  logic [DATA_W-1:0]        i_wdata0,
  input  logic                     i_we1,
  input  logic [$clog2(DEPTH)-1:0] i_waddr1,
  input  logic [DATA_W-1:0]        i_wdata1,
  input  logic [$clog2(DEPTH)-1:0] i_raddr0,
  input  logic [$clog2(DEPTH)-1:0] i_raddr1,
  output logic [DATA_W-1:0]        o_rdata0,
  output logic [DATA_W-1:0]        o_rdata1
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/dispatch_buffer.sv
// 2-wide in-order FIFO between decode and rename/dispatch; DISPATCH_BUF_STATS_EN adds stall/occupancy stats.
// Latency: an uop enqueued in cycle N is visible on o_valid/o_data in cycle N+1 (no bypass).
// Backpressure: o_stall from registered count only (fewer than 2 free slots); inputs ignored while stalled.
module dispatch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = UOP_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ext_flush,
  input  logic [ISSUE_W-1:0]             i_valid,
  input  logic [ISSUE_W-1:0][DATA_W-1:0] i_data,
  output logic                           o_stall,
  output logic [ISSUE_W-1:0]             o_valid,
  output logic [ISSUE_W-1:0][DATA_W-1:0] o_data,
  input  logic [ISSUE_W-1:0]             i_take
`ifdef DISPATCH_BUF_STATS_EN
  ,
  output logic [31:0]                    o_stall_cycles,
  output logic [ptr_w(DEPTH)-1:0]        o_max_occ
`endif
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     r_head, r_tail;
  logic [PW-1:0]     w_count;
  logic [1:0]        w_take_legal, w_deq, w_enq;
  logic [1:0]        w_n_deq, w_n_enq;
  logic              w_clear;
  logic [AW-1:0]     w_waddr0, w_waddr1, w_raddr0, w_raddr1;
  logic [DATA_W-1:0] w_wdata0, w_rdata0, w_rdata1;

  assign w_count = r_tail - r_head;
  assign w_clear = reset | ext_flush;

  assign o_stall    = w_count > PW'(DEPTH - 2);
  assign o_valid[0] = w_count != '0;
  assign o_valid[1] = w_count >= PW'(2);

  // A non-prefix take (10) is dropped entirely rather than partially honoured.
  assign w_take_legal = (i_take == 2'b10) ? 2'b00 : i_take;
  assign w_deq        = w_take_legal & o_valid;
  assign w_n_deq      = {1'b0, w_deq[0]} + {1'b0, w_deq[1]};

  assign w_enq   = o_stall ? 2'b00 : i_valid;
  assign w_n_enq = {1'b0, w_enq[0]} + {1'b0, w_enq[1]};

  // Compact lanes: the first valid uop always lands at tail.
  assign w_waddr0 = r_tail[AW-1:0];
  assign w_waddr1 = r_tail[AW-1:0] + AW'(1);
  assign w_wdata0 = w_enq[0] ? i_data[0] : i_data[1];
  assign w_raddr0 = r_head[AW-1:0];
  assign w_raddr1 = r_head[AW-1:0] + AW'(1);

  ring_ram_2w2r #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk      (clk),
    .i_we0    ((|w_enq) & ~w_clear),
    .i_waddr0 (w_waddr0),
    .i_wdata0 (w_wdata0),
    .i_we1    ((&w_enq) & ~w_clear),
    .i_waddr1 (w_waddr1),
    .i_wdata1 (i_data[1]),
    .i_raddr0 (w_raddr0),
    .i_raddr1 (w_raddr1),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  assign o_data[0] = o_valid[0] ? w_rdata0 : '0;
  assign o_data[1] = o_valid[1] ? w_rdata1 : '0;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_head <= r_head + PW'(w_n_deq);
      r_tail <= r_tail + PW'(w_n_enq);
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (w_count <= PW'(DEPTH))
        else $error("dispatch_buffer: occupancy %0d exceeds depth", w_count);
      assert (i_take != 2'b10)
        else $warning("dispatch_buffer: non-prefix i_take=10 ignored");
    end
  end

`ifdef DISPATCH_BUF_STATS_EN
  logic [31:0]   r_stall_cycles;
  logic [PW-1:0] r_max_occ;

  // Statistics survive ext_flush so they span whole runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_max_occ      <= '0;
    end else begin
      if (o_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_count > r_max_occ) r_max_occ <= w_count;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_max_occ      = r_max_occ;
`endif
endmodule
